// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared definitions for the BlackParrot FPGA host MMIO decoder.
//   - state_e : request-handling FSM states
//   - default MMIO addresses for putchar / getchar / finish
//   - EOF word returned by a non-blocking getchar with no character waiting
package blackparrot_fpga_host_pkg;

  typedef enum logic [2:0] {
    e_addr,
    e_data,
    e_putchar,
    e_getchar,
    e_finish,
    e_fwd_addr,
    e_fwd_data
  } state_e;

  localparam logic [31:0] putchar_addr_gp = 32'h0010_1000;
  localparam logic [31:0] getchar_addr_gp = 32'h0010_0000;
  localparam logic [31:0] finish_base_gp  = 32'h0010_2000;
  localparam logic [31:0] eof_data_gp     = 32'hFFFF_FFFF;

endpackage

// File: rtl/blackparrot_fpga_host_finish_tracker.sv
// Per-core finish/fail tracking.
//   addr_i         : captured request address; hit_o flags a finish address
//                    for some core i < num_core_p (bits [2:0] ignored)
//   code_i         : finish code; nonzero marks the core as failed
//   set_i          : apply the finish write for the decoded core
//   finish_o/fail_o: sticky per-core flags; all_finished_o = &finish_o
module blackparrot_fpga_host_finish_tracker
  import blackparrot_fpga_host_pkg::*;
#(
  parameter int          num_core_p    = 1,
  parameter logic [31:0] finish_base_p = finish_base_gp
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           addr_i,
  input  logic [7:0]            code_i,
  input  logic                  set_i,
  output logic                  hit_o,
  output logic [num_core_p-1:0] finish_o,
  output logic [num_core_p-1:0] fail_o,
  output logic                  all_finished_o
);

  logic [num_core_p-1:0] hit_vec;
  logic [num_core_p-1:0] finish_r, fail_r;

  // One-hot core select: core i owns the 8-byte slot at finish_base_p + 8*i.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < num_core_p; i++) begin
      hit_vec[i] = (addr_i[31:3] == (finish_base_p[31:3] + 29'(i)));
    end
  end

  assign hit_o = |hit_vec;

  // Flags are sticky; a repeated finish can only add failure, never clear it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      finish_r <= '0;
      fail_r   <= '0;
    end else if (set_i) begin
      finish_r <= finish_r | hit_vec;
      fail_r   <= fail_r | (hit_vec & {num_core_p{code_i != 8'h00}});
    end
  end

  assign finish_o       = finish_r;
  assign fail_o         = fail_r;
  assign all_finished_o = &finish_r;

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO.
//   v_i/ready_o/data_i : enqueue side (valid/ready, ready independent of v_i)
//   v_o/data_o/yumi_i  : dequeue side (valid/yumi)
// Storage is not reset; only pointers and occupancy are.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wptr_r, rptr_r;
  logic [ptr_w:0]     count_r;
  logic               enq, deq;

  assign ready_o = (count_r != (ptr_w+1)'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_w'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/blackparrot_fpga_host_mmio_decoder.sv
// Host-side MMIO front-end for BlackParrot.
// Consumes (address, data) word pairs from the MMIO request FIFO, serves
// putchar / getchar / finish locally and forwards every other request to host
// software. Software responses and local getchar responses share one
// response stream (BP keeps at most one MMIO request outstanding).
// Ports:
//   req_*        : request words in (valid/yumi)
//   fwd_*        : forwarded words to software (valid/yumi)
//   host_resp_*  : software responses in (valid/ready)
//   resp_*       : responses to the BP response FIFO (valid/ready)
//   char_out_*   : putchar bytes out of an internal buffer (valid/yumi)
//   char_in_*    : getchar bytes in (valid/yumi)
//   finish_o, fail_o, all_finished_o : sticky per-core completion status
// Build option: BLACKPARROT_FPGA_HOST_GETCHAR_BLOCKING_EN makes getchar wait
// for a character; by default an empty getchar returns EOF immediately.
module blackparrot_fpga_host_mmio_decoder
  import blackparrot_fpga_host_pkg::*;
#(
  parameter int          fifo_data_width_p = 32,
  parameter int          num_core_p        = 1,
  parameter logic [31:0] putchar_addr_p    = putchar_addr_gp,
  parameter logic [31:0] getchar_addr_p    = getchar_addr_gp,
  parameter logic [31:0] finish_base_p     = finish_base_gp,
  parameter int          char_els_p        = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_v_i,
  input  logic [fifo_data_width_p-1:0] req_data_i,
  output logic                         req_yumi_o,
  output logic                         fwd_v_o,
  output logic [fifo_data_width_p-1:0] fwd_data_o,
  input  logic                         fwd_yumi_i,
  input  logic                         host_resp_v_i,
  input  logic [fifo_data_width_p-1:0] host_resp_data_i,
  output logic                         host_resp_ready_and_o,
  output logic                         resp_v_o,
  output logic [fifo_data_width_p-1:0] resp_data_o,
  input  logic                         resp_ready_and_i,
  output logic                         char_out_v_o,
  output logic [7:0]                   char_out_data_o,
  input  logic                         char_out_yumi_i,
  input  logic                         char_in_v_i,
  input  logic [7:0]                   char_in_data_i,
  output logic                         char_in_yumi_o,
  output logic [num_core_p-1:0]        finish_o,
  output logic [num_core_p-1:0]        fail_o,
  output logic                         all_finished_o
);

  state_e                       state_r, state_n;
  logic [fifo_data_width_p-1:0] addr_r, data_r;
  logic                         char_v, char_ready, char_fifo_v;
  logic                         finish_set, finish_hit;

  always_comb begin
    state_n               = state_r;
    req_yumi_o            = 1'b0;
    fwd_v_o               = 1'b0;
    fwd_data_o            = addr_r;
    resp_v_o              = host_resp_v_i;
    resp_data_o           = host_resp_data_i;
    host_resp_ready_and_o = resp_ready_and_i;
    char_in_yumi_o        = 1'b0;
    char_v                = 1'b0;
    finish_set            = 1'b0;

    case (state_r)
      e_addr: begin
        req_yumi_o = req_v_i;
        if (req_v_i) state_n = e_data;
      end
      e_data: begin
        req_yumi_o = req_v_i;
        if (req_v_i) begin
          if (addr_r == putchar_addr_p)      state_n = e_putchar;
          else if (addr_r == getchar_addr_p) state_n = e_getchar;
          else if (finish_hit)               state_n = e_finish;
          else                               state_n = e_fwd_addr;
        end
      end
      e_putchar: begin
        char_v = 1'b1;
        if (char_ready) state_n = e_addr;
      end
      e_getchar: begin
        // The response port belongs to the local getchar here.
        host_resp_ready_and_o = 1'b0;
        if (char_in_v_i) begin
          resp_v_o       = 1'b1;
          resp_data_o    = {{(fifo_data_width_p-8){1'b0}}, char_in_data_i};
          char_in_yumi_o = resp_ready_and_i;
          if (resp_ready_and_i) state_n = e_addr;
        end else begin
`ifdef BLACKPARROT_FPGA_HOST_GETCHAR_BLOCKING_EN
          resp_v_o    = 1'b0;
          resp_data_o = {{(fifo_data_width_p-8){1'b0}}, char_in_data_i};
`else
          resp_v_o    = 1'b1;
          resp_data_o = eof_data_gp;
          if (resp_ready_and_i) state_n = e_addr;
`endif
        end
      end
      e_finish: begin
        finish_set = 1'b1;
        state_n    = e_addr;
      end
      e_fwd_addr: begin
        fwd_v_o    = 1'b1;
        fwd_data_o = addr_r;
        if (fwd_yumi_i) state_n = e_fwd_data;
      end
      e_fwd_data: begin
        fwd_v_o    = 1'b1;
        fwd_data_o = data_r;
        if (fwd_yumi_i) state_n = e_addr;
      end
      default: state_n = e_addr;
    endcase

    // Nothing is offered or consumed while reset is held.
    if (reset_i) begin
      state_n               = e_addr;
      req_yumi_o            = 1'b0;
      fwd_v_o               = 1'b0;
      resp_v_o              = 1'b0;
      host_resp_ready_and_o = 1'b0;
      char_in_yumi_o        = 1'b0;
      char_v                = 1'b0;
      finish_set            = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_addr;
    else         state_r <= state_n;
  end

  // Request words are held without reset; the FSM restart alone discards a
  // partially received request.
  always_ff @(posedge clk_i) begin
    if (req_yumi_o && (state_r == e_addr)) addr_r <= req_data_i;
    if (req_yumi_o && (state_r == e_data)) data_r <= req_data_i;
  end

  bsg_fifo_1r1w_small #(
    .width_p(8),
    .els_p  (char_els_p)
  ) char_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (char_v),
    .ready_o(char_ready),
    .data_i (data_r[7:0]),
    .v_o    (char_fifo_v),
    .data_o (char_out_data_o),
    .yumi_i (char_out_yumi_i)
  );

  assign char_out_v_o = char_fifo_v & ~reset_i;

  blackparrot_fpga_host_finish_tracker #(
    .num_core_p   (num_core_p),
    .finish_base_p(finish_base_p)
  ) finish_tracker (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .addr_i        (addr_r[31:0]),
    .code_i        (data_r[7:0]),
    .set_i         (finish_set),
    .hit_o         (finish_hit),
    .finish_o      (finish_o),
    .fail_o        (fail_o),
    .all_finished_o(all_finished_o)
  );

endmodule

// File: tb/tb_blackparrot_fpga_host_mmio_decoder.sv
// Scoreboard bench for blackparrot_fpga_host_mmio_decoder (num_core_p = 2).
module tb_blackparrot_fpga_host_mmio_decoder;

  localparam int          NUM    = 2;
  localparam int          ELS    = 16;
  localparam int          BUDGET = 2000;
  localparam logic [31:0] PUT    = 32'h0010_1000;
  localparam logic [31:0] GET    = 32'h0010_0000;
  localparam logic [31:0] FIN    = 32'h0010_2000;
  localparam logic [31:0] EOF    = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic            req_v_i = 1'b0;
  logic [31:0]     req_data_i = '0;
  logic            req_yumi_o;
  logic            fwd_v_o;
  logic [31:0]     fwd_data_o;
  logic            fwd_yumi_i = 1'b0;
  logic            host_resp_v_i = 1'b0;
  logic [31:0]     host_resp_data_i = '0;
  logic            host_resp_ready_and_o;
  logic            resp_v_o;
  logic [31:0]     resp_data_o;
  logic            resp_ready_and_i = 1'b0;
  logic            char_out_v_o;
  logic [7:0]      char_out_data_o;
  logic            char_out_yumi_i = 1'b0;
  logic            char_in_v_i = 1'b0;
  logic [7:0]      char_in_data_i = '0;
  logic            char_in_yumi_o;
  logic [NUM-1:0]  finish_o, fail_o;
  logic            all_finished_o;

  int checks = 0;
  int errors = 0;
  int resp_seen = 0;
  int req_words = 0;
  int char_yumis = 0;
  int exp_yumis = 0;
  bit fwd_stall = 1'b0;
  bit char_drain = 1'b1;
  bit host_acc = 1'b0;
  bit [NUM-1:0] fin_m = '0;
  bit [NUM-1:0] fail_m = '0;

  logic [31:0] exp_resp[$];
  logic [31:0] exp_fwd[$];
  logic [31:0] host_q[$];
  logic [7:0]  exp_char[$];

  blackparrot_fpga_host_mmio_decoder #(
    .fifo_data_width_p(32),
    .num_core_p       (NUM),
    .putchar_addr_p   (PUT),
    .getchar_addr_p   (GET),
    .finish_base_p    (FIN),
    .char_els_p       (ELS)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .req_v_i              (req_v_i),
    .req_data_i           (req_data_i),
    .req_yumi_o           (req_yumi_o),
    .fwd_v_o              (fwd_v_o),
    .fwd_data_o           (fwd_data_o),
    .fwd_yumi_i           (fwd_yumi_i),
    .host_resp_v_i        (host_resp_v_i),
    .host_resp_data_i     (host_resp_data_i),
    .host_resp_ready_and_o(host_resp_ready_and_o),
    .resp_v_o             (resp_v_o),
    .resp_data_o          (resp_data_o),
    .resp_ready_and_i     (resp_ready_and_i),
    .char_out_v_o         (char_out_v_o),
    .char_out_data_o      (char_out_data_o),
    .char_out_yumi_i      (char_out_yumi_i),
    .char_in_v_i          (char_in_v_i),
    .char_in_data_i       (char_in_data_i),
    .char_in_yumi_o       (char_in_yumi_o),
    .finish_o             (finish_o),
    .fail_o               (fail_o),
    .all_finished_o       (all_finished_o)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s got timeout/unexpected expected handshake", name);
  endtask

  // Consumer/producer side of the DUT's outputs: random backpressure, and the
  // software responder that replays queued host responses.
  initial begin
    forever begin
      @(negedge clk);
      if (host_resp_v_i && host_acc) begin
        host_q.delete(0);
        host_resp_v_i = 1'b0;
      end
      if (!host_resp_v_i && host_q.size() > 0) begin
        host_resp_v_i    = 1'b1;
        host_resp_data_i = host_q[0];
      end
      resp_ready_and_i = ($urandom_range(3) != 0);
      fwd_yumi_i       = fwd_v_o && !fwd_stall && ($urandom_range(2) != 0);
      char_out_yumi_i  = char_out_v_o && char_drain && ($urandom_range(1) != 0);
      #4;
      host_acc = host_resp_v_i && host_resp_ready_and_o;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset_i) begin
        if (req_v_i && req_yumi_o) req_words++;
        if (resp_v_o) begin
          if (exp_resp.size() == 0) fail_now("resp_unexpected");
          else if (resp_ready_and_i) begin
            check32("resp_data", resp_data_o, exp_resp[0]);
            exp_resp.delete(0);
            resp_seen++;
          end
        end
        if (fwd_v_o) begin
          if (exp_fwd.size() == 0) fail_now("fwd_unexpected");
          else if (fwd_yumi_i) begin
            check32("fwd_data", fwd_data_o, exp_fwd[0]);
            exp_fwd.delete(0);
          end
        end
        if (char_out_v_o && char_out_yumi_i) begin
          if (exp_char.size() == 0) fail_now("char_out_unexpected");
          else begin
            check32("char_out", {24'h0, char_out_data_o}, {24'h0, exp_char[0]});
            exp_char.delete(0);
          end
        end
        if (char_in_yumi_o) begin
          if (!char_in_v_i) fail_now("char_in_yumi_without_v");
          else char_yumis++;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    req_v_i    = 1'b1;
    req_data_i = w;
    #4;
    while (!req_yumi_o && n < BUDGET) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!req_yumi_o) fail_now("req_accept");
    @(negedge clk);
    req_v_i = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_seen < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (resp_seen < target) fail_now("resp_wait");
  endtask

  task automatic wait_fwd_empty();
    int n = 0;
    while (exp_fwd.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_fwd.size() != 0) fail_now("fwd_wait");
  endtask

  task automatic wait_char_empty();
    int n = 0;
    while (exp_char.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_char.size() != 0) fail_now("char_drain_wait");
  endtask

  // Reference behaviour of one MMIO request, decided from the address map.
  task automatic do_request(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] aux, input bit present);
    int tgt;
    int unsigned idx;
    idx = (addr >= FIN) ? ((addr - FIN) >> 3) : NUM;
    if (addr == PUT) begin
      exp_char.push_back(data[7:0]);
      send_word(addr);
      send_word(data);
    end else if (addr == GET) begin
      tgt = resp_seen + 1;
      if (present) begin
        char_in_v_i    = 1'b1;
        char_in_data_i = aux[7:0];
        exp_resp.push_back({24'h0, aux[7:0]});
        exp_yumis++;
        send_word(addr);
        send_word(data);
        wait_resp(tgt);
        char_in_v_i = 1'b0;
      end else begin
`ifdef BLACKPARROT_FPGA_HOST_GETCHAR_BLOCKING_EN
        send_word(addr);
        send_word(data);
        repeat (6) @(negedge clk);
        check32("getchar_block_hold", 32'(resp_seen), 32'(tgt - 1));
        char_in_v_i    = 1'b1;
        char_in_data_i = aux[7:0];
        exp_resp.push_back({24'h0, aux[7:0]});
        exp_yumis++;
        wait_resp(tgt);
        char_in_v_i = 1'b0;
`else
        exp_resp.push_back(EOF);
        send_word(addr);
        send_word(data);
        wait_resp(tgt);
`endif
      end
    end else if (idx < NUM) begin
      send_word(addr);
      send_word(data);
      repeat (2) @(negedge clk);
      fin_m[idx] = 1'b1;
      if (data[7:0] != 8'h00) fail_m[idx] = 1'b1;
      check32("finish_o", 32'(finish_o), 32'(fin_m));
      check32("fail_o", 32'(fail_o), 32'(fail_m));
      check32("all_finished_o", 32'(all_finished_o), 32'(&fin_m));
    end else begin
      tgt = resp_seen + 1;
      exp_fwd.push_back(addr);
      exp_fwd.push_back(data);
      send_word(addr);
      send_word(data);
      wait_fwd_empty();
      host_q.push_back(aux);
      exp_resp.push_back(aux);
      wait_resp(tgt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rw0;
    logic [31:0] a, d, x;
    // Reset: nothing offered or consumed even with a request pending.
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    req_v_i = 1'b1;
    #4;
    check32("reset_req_yumi", 32'(req_yumi_o), 32'd0);
    @(negedge clk);
    req_v_i = 1'b0;
    reset_i = 1'b0;
    #4;
    check32("reset_finish", 32'(finish_o), 32'd0);
    check32("reset_fail", 32'(fail_o), 32'd0);
    check32("reset_all_finished", 32'(all_finished_o), 32'd0);
    check32("reset_fwd_v", 32'(fwd_v_o), 32'd0);
    check32("reset_char_out_v", 32'(char_out_v_o), 32'd0);
    check32("reset_resp_v", 32'(resp_v_o), 32'd0);
    @(negedge clk);

    // Directed cases.
    do_request(PUT, 32'h0000_0041, 32'h0, 1'b0);
    wait_char_empty();
    do_request(GET, 32'h0, 32'h0000_005A, 1'b1);
    do_request(GET, 32'h0, 32'h0000_0063, 1'b0);
    do_request(FIN + 32'd8, 32'd0, 32'h0, 1'b0);
    do_request(FIN, 32'd3, 32'h0, 1'b0);
    check32("finish_pair", 32'(finish_o), 32'h3);
    check32("fail_pair", 32'(fail_o), 32'h1);
    check32("all_finished_pair", 32'(all_finished_o), 32'h1);
    do_request(FIN + 32'd8, 32'd5, 32'h0, 1'b0);
    do_request(FIN + 32'd8, 32'd0, 32'h0, 1'b0);
    check32("fail_sticky", 32'(fail_o), 32'h3);
    do_request(FIN + 32'd16, 32'd0, 32'h0000_0777, 1'b0);

    // Forward with the software side stalled for a while.
    fwd_stall = 1'b1;
    fork
      do_request(32'h0020_0000, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
      begin
        repeat (8) @(negedge clk);
        check32("fwd_stall_v", 32'(fwd_v_o), 32'd1);
        check32("fwd_stall_pending", 32'(exp_fwd.size()), 32'd2);
        fwd_stall = 1'b0;
      end
    join

    // Putchar backpressure: buffer fills, request intake stops, nothing lost.
    char_drain = 1'b0;
    rw0 = req_words;
    fork
      for (int i = 0; i < ELS + 2; i++) do_request(PUT, 32'h30 + 32'(i), 32'h0, 1'b0);
      begin
        repeat (200) @(negedge clk);
        check32("bp_words_accepted", 32'(req_words - rw0), 32'(2 * ELS + 2));
        check32("bp_char_out_v", 32'(char_out_v_o), 32'd1);
        check32("bp_chars_pending", 32'(exp_char.size()), 32'(ELS + 2));
        char_drain = 1'b1;
      end
    join
    wait_char_empty();

    // Reset in the middle of a request.
    send_word(PUT);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    fin_m  = '0;
    fail_m = '0;
    #4;
    check32("midreset_finish", 32'(finish_o), 32'd0);
    check32("midreset_fail", 32'(fail_o), 32'd0);
    @(negedge clk);
    do_request(PUT, 32'h0000_0055, 32'h0, 1'b0);
    do_request(32'h0030_0000, 32'h0BAD_F00D, 32'h0000_4321, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      x = $urandom;
      case ($urandom_range(4))
        0: do_request(PUT, $urandom, 32'h0, 1'b0);
        1: do_request(GET, $urandom, x, ($urandom_range(1) != 0));
        2: begin
          a = FIN + 32'(8 * $urandom_range(NUM)) + 32'($urandom_range(7));
          d = ($urandom_range(3) == 0) ? $urandom : 32'h0;
          do_request(a, d, x, 1'b0);
        end
        default: begin
          a = $urandom;
          d = $urandom;
          do_request(a, d, x, 1'b0);
        end
      endcase
    end

    wait_char_empty();
    repeat (4) @(negedge clk);
    check32("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    check32("fwd_queue_empty", 32'(exp_fwd.size()), 32'd0);
    check32("char_in_yumi_count", 32'(char_yumis), 32'(exp_yumis));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
